// File: rtl/switch_pkg.sv
// Shared switch parameters: default port count, flit width and queue depth,
// plus the derived index/count widths used by the input queues and the arbiter.
package switch_pkg;

   localparam int NPORTS_DEF = 4;
   localparam int DW_DEF     = 8;
   localparam int DEPTH_DEF  = 4;

   // Index width that never collapses to zero bits for single-entry ranges
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PORT_W = idx_w(NPORTS_DEF);
   localparam int CNT_W  = $clog2(DEPTH_DEF) + 1;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_ONE,
      GNT_MULTI
   } gnt_class_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for one switch input port; exposes the head flit
// combinationally so the top level can register it on a pop.
module sync_fifo
   import switch_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          ready,
   output logic          nonempty
);

   localparam int AW = idx_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push_en;
   logic          pop_en;

   assign ready    = (count != CW'(DEPTH));
   assign nonempty = (count != '0);
   assign push_en  = push & ready;
   assign pop_en   = pop & nonempty;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count alone
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/switch_input_queues.sv
// Per-port input queues feeding a round-robin arbiter: decodes the grant,
// pops the granted queue and registers the flit with its source port.
module switch_input_queues
   import switch_pkg::*;
#(
   parameter  int NPORTS = NPORTS_DEF,
   parameter  int DW     = DW_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int PW     = idx_w(NPORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NPORTS-1:0]    in_valid,
   input  logic [NPORTS*DW-1:0] in_data,
   output logic [NPORTS-1:0]    in_ready,
   output logic [NPORTS-1:0]    REQ,
   input  logic [NPORTS-1:0]    GNT,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [PW-1:0]        out_port,
   output logic                 gnt_err
);

   logic [DW-1:0]     head [NPORTS];
   logic [NPORTS-1:0] pop_p0;

   for (genvar i = 0; i < NPORTS; i++) begin : g_q
      sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (in_valid[i]),
         .din      (in_data[i*DW +: DW]),
         .pop      (pop_p0[i]),
         .head     (head[i]),
         .ready    (in_ready[i]),
         .nonempty (REQ[i])
      );
   end

   // Stage p0: grant decode and head selection
   gnt_class_e    gnt_class_p0;
   logic          pop_any_p0;
   logic [PW-1:0] pop_idx_p0;
   logic [DW-1:0] pop_data_p0;

   always_comb begin
      gnt_class_p0 = GNT_IDLE;
      pop_p0       = '0;
      pop_idx_p0   = '0;
      pop_data_p0  = '0;
      if ($countones(GNT) > 1)       gnt_class_p0 = GNT_MULTI;
      else if ($countones(GNT) == 1) gnt_class_p0 = GNT_ONE;
      // A grant to an empty queue is legal but simply yields nothing
      if (gnt_class_p0 == GNT_ONE) pop_p0 = GNT & REQ;
      for (int i = 0; i < NPORTS; i++) begin
         if (pop_p0[i]) begin
            pop_idx_p0  = PW'(i);
            pop_data_p0 = head[i];
         end
      end
   end

   assign pop_any_p0 = |pop_p0;

   // Stage p1: registered output flit and sticky grant error
   logic          vld_p1;
   logic [DW-1:0] data_p1;
   logic [PW-1:0] port_p1;
   logic          gnt_err_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         data_p1    <= '0;
         port_p1    <= '0;
         gnt_err_p1 <= 1'b0;
      end else begin
         vld_p1 <= pop_any_p0;
         if (pop_any_p0) begin
            data_p1 <= pop_data_p0;
            port_p1 <= pop_idx_p0;
         end
         if (gnt_class_p0 == GNT_MULTI) gnt_err_p1 <= 1'b1;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_port  = port_p1;
   assign gnt_err   = gnt_err_p1;

endmodule

// File: tb/tb_switch_input_queues.sv
// Directed bench for switch_input_queues with hand-computed expectations
// checked through immediate assertions.
module tb_switch_input_queues;

   localparam int NP = 4;
   localparam int W  = 8;

   logic          clk;
   logic          rst;
   logic [NP-1:0] in_valid;
   logic [NP*W-1:0] in_data;
   logic [NP-1:0] in_ready;
   logic [NP-1:0] req;
   logic [NP-1:0] gnt;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [1:0]    out_port;
   logic          gnt_err;

   int n_vec;
   int n_err;

   switch_input_queues #(.NPORTS(NP), .DW(W), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .REQ       (req),
      .GNT       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_port  (out_port),
      .gnt_err   (gnt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] p);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".port"},  32'(out_port),  32'(p));
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = '0;
      in_data  = '0;
      gnt      = '0;
      #3;
      chk("rst.req",      32'(req),       32'h0);
      chk("rst.in_ready", 32'(in_ready),  32'hF);
      chk("rst.out_valid",32'(out_valid), 32'h0);
      chk("rst.out_data", 32'(out_data),  32'h0);
      chk("rst.out_port", 32'(out_port),  32'h0);
      chk("rst.gnt_err",  32'(gnt_err),   32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single flit through port 2
      in_valid[2] = 1'b1; in_data[2*W +: W] = 8'hA5;
      tick();
      in_valid = '0;
      chk("single.req_up", 32'(req), 32'h4);
      gnt = 4'b0100;
      tick();
      gnt = '0;
      chk_out("single.out", 8'hA5, 2'd2);
      chk("single.req_down", 32'(req), 32'h0);
      tick();
      chk("single.idle_valid", 32'(out_valid), 32'h0);
      chk("single.hold_data",  32'(out_data),  32'hA5);
      chk("single.hold_port",  32'(out_port),  32'h2);

      // Fill port 0; fifth flit is dropped
      for (int k = 1; k <= 5; k++) begin
         in_valid[0] = 1'b1; in_data[0 +: W] = 8'(k);
         tick();
         if (k == 3) chk("full.ready_3", 32'(in_ready[0]), 32'h1);
         if (k == 4) chk("full.ready_4", 32'(in_ready[0]), 32'h0);
      end
      in_valid = '0;
      chk("full.ready_5", 32'(in_ready[0]), 32'h0);
      gnt = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_out("full.drain", 8'(k), 2'd0);
      end
      tick();
      gnt = '0;
      chk("full.drop_valid", 32'(out_valid), 32'h0);
      chk("full.req_empty",  32'(req),       32'h0);

      // Port 1 full, then simultaneous push/pop
      for (int k = 0; k < 4; k++) begin
         in_valid[1] = 1'b1; in_data[1*W +: W] = 8'h21 + 8'(k);
         tick();
      end
      chk("pp.full", 32'(in_ready[1]), 32'h0);
      gnt = 4'b0010; in_data[1*W +: W] = 8'h25;
      tick();
      chk_out("pp.pop1", 8'h21, 2'd1);
      chk("pp.ready_after_block", 32'(in_ready[1]), 32'h1);
      in_data[1*W +: W] = 8'h26;
      tick();
      in_valid = '0;
      chk_out("pp.pop2", 8'h22, 2'd1);
      chk("pp.count_stays3", 32'(in_ready[1]), 32'h1);
      tick(); chk_out("pp.pop3", 8'h23, 2'd1);
      tick(); chk_out("pp.pop4", 8'h24, 2'd1);
      tick(); chk_out("pp.pop5", 8'h26, 2'd1);
      tick();
      gnt = '0;
      chk("pp.empty_valid", 32'(out_valid), 32'h0);
      chk("pp.req_empty",   32'(req),       32'h0);

      // Illegal two-hot grant
      in_valid = 4'b1001;
      in_data[0 +: W] = 8'h31; in_data[3*W +: W] = 8'h32;
      tick();
      in_valid = '0;
      chk("ill.req", 32'(req), 32'h9);
      gnt = 4'b1001;
      tick();
      gnt = '0;
      chk("ill.valid",   32'(out_valid), 32'h0);
      chk("ill.err",     32'(gnt_err),   32'h1);
      chk("ill.req_kept",32'(req),       32'h9);
      tick();
      chk("ill.err_sticky", 32'(gnt_err), 32'h1);
      gnt = 4'b0001;
      tick(); chk_out("ill.pop0", 8'h31, 2'd0);
      gnt = 4'b1000;
      tick(); chk_out("ill.pop3", 8'h32, 2'd3);
      gnt = '0;
      chk("ill.err_sticky2", 32'(gnt_err), 32'h1);
      chk("ill.req_empty",   32'(req),     32'h0);

      // Wrap-around on port 3 with grant held
      gnt = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         in_valid[3] = 1'b1; in_data[3*W +: W] = 8'h10 + 8'(k);
         tick();
         if (k == 0) begin
            chk("wrap.first_novalid", 32'(out_valid), 32'h0);
            chk("wrap.first_req",     32'(req),       32'h8);
         end else begin
            chk_out("wrap.out", 8'h10 + 8'(k - 1), 2'd3);
         end
      end
      in_valid = '0;
      tick(); chk_out("wrap.last", 8'h19, 2'd3);
      tick();
      gnt = '0;
      chk("wrap.done_valid", 32'(out_valid), 32'h0);
      chk("wrap.req_empty",  32'(req),       32'h0);

      // Reset mid-operation
      in_valid = 4'b1111; in_data = 32'h44332211;
      tick(); tick();
      in_valid = '0;
      chk("mrst.req_full", 32'(req), 32'hF);
      gnt = 4'b0001;
      tick();
      chk_out("mrst.pre_pop", 8'h11, 2'd0);
      #3 rst = 1'b1;
      #1;
      chk("mrst.req",       32'(req),       32'h0);
      chk("mrst.in_ready",  32'(in_ready),  32'hF);
      chk("mrst.out_valid", 32'(out_valid), 32'h0);
      chk("mrst.out_data",  32'(out_data),  32'h0);
      chk("mrst.gnt_err",   32'(gnt_err),   32'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("mrst.no_pop",    32'(out_valid), 32'h0);
      chk("mrst.req_after", 32'(req),       32'h0);
      gnt = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
